// File: rtl/baudgen_frac.sv
// Fractional, runtime-programmable baud generator.
// Produces oversample strobe, baud strobe and 50% duty baud clock.
module baudgen_frac #(
    parameter int HIGH_CLK   = 50_000_000,
    parameter int BAUD_CLK   = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 8
) (
    input  logic                    high_clk_in,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sync_clr,
    input  logic [DIV_W+FRAC_W-1:0] div_in,
    input  logic                    div_load,
    output logic                    div_pending,
    output logic                    div_err,
    output logic                    os_tick,
    output logic                    baud_tick,
    output logic                    baud_clk_out
);

    localparam int DW   = DIV_W + FRAC_W;
    localparam int OS_W = $clog2(OVERSAMPLE);

    localparam logic [63:0] NUM     = 64'(HIGH_CLK) << FRAC_W;
    localparam logic [63:0] DEN     = 64'(BAUD_CLK) * 64'(OVERSAMPLE);
    localparam logic [63:0] DEF_64  = (NUM + DEN / 2) / DEN;
    localparam logic [DW-1:0] DEF_DIV = DEF_64[DW-1:0];

    localparam logic [DW:0]   ONE     = (DW+1)'(1) << FRAC_W;
    localparam logic [DW-1:0] MIN_DIV = DW'(2) << FRAC_W;

    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF1 = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DW:0]     acc;
    logic [DW:0]     sum;
    logic [DW-1:0]   div_act;
    logic [DW-1:0]   shadow;
    logic [DW-1:0]   div_clamped;
    logic            div_low;
    logic            hit;
    logic [OS_W-1:0] os_cnt;

    always_comb begin
        sum         = acc + ONE;
        hit         = enable && !sync_clr && (sum >= {1'b0, div_act});
        div_low     = div_in < MIN_DIV;
        div_clamped = div_low ? MIN_DIV : div_in;
    end

    always_ff @(posedge high_clk_in or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            os_cnt       <= '0;
            os_tick      <= 1'b0;
            baud_tick    <= 1'b0;
            baud_clk_out <= 1'b1;
        end else begin
            os_tick   <= 1'b0;
            baud_tick <= 1'b0;
            if (sync_clr) begin
                acc          <= '0;
                os_cnt       <= '0;
                baud_clk_out <= 1'b1;
            end else if (enable) begin
                if (hit) begin
                    acc       <= sum - {1'b0, div_act};
                    os_tick   <= 1'b1;
                    baud_tick <= (os_cnt == OS_LAST);
                    os_cnt    <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
                    // Toggle entering count 0 and OVERSAMPLE/2 for exact 50% duty
                    if (os_cnt == OS_LAST || os_cnt == OS_HALF1)
                        baud_clk_out <= ~baud_clk_out;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    // New divisor only lands on a tick boundary (or while frozen)
    always_ff @(posedge high_clk_in or posedge reset) begin
        if (reset) begin
            div_act     <= DEF_DIV;
            shadow      <= DEF_DIV;
            div_pending <= 1'b0;
            div_err     <= 1'b0;
        end else if (div_load) begin
            shadow      <= div_clamped;
            div_pending <= 1'b1;
            if (div_low)
                div_err <= 1'b1;
        end else if (div_pending && (hit || !enable)) begin
            div_act     <= shadow;
            div_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baudgen_frac.sv
// Self-checking bench for baudgen_frac.
// Table of divisor loads plus hand-written timing sequences.
module tb_baudgen_frac;

    localparam int DW = 24;

    logic          high_clk_in = 1'b0;
    logic          reset       = 1'b1;
    logic          enable      = 1'b0;
    logic          sync_clr    = 1'b0;
    logic          div_load    = 1'b0;
    logic [DW-1:0] div_in      = '0;
    logic          div_pending;
    logic          div_err;
    logic          os_tick;
    logic          baud_tick;
    logic          baud_clk_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] div;
        int            nt;
        int            sum;
        int            lo;
        int            hi;
        logic          err;
    } vec_t;

    vec_t vecs[5];
    vec_t sb[$];
    int   exp_q[$];

    always #5 high_clk_in = ~high_clk_in;

    baudgen_frac dut (
        .high_clk_in  (high_clk_in),
        .reset        (reset),
        .enable       (enable),
        .sync_clr     (sync_clr),
        .div_in       (div_in),
        .div_load     (div_load),
        .div_pending  (div_pending),
        .div_err      (div_err),
        .os_tick      (os_tick),
        .baud_tick    (baud_tick),
        .baud_clk_out (baud_clk_out)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge high_clk_in);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!os_tick && n < 2000);
        if (!os_tick)
            chk("os_tick_timeout", n, -1);
    endtask

    task automatic wait_bclk(input logic v, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (baud_clk_out !== v && n < 2000);
        if (baud_clk_out !== v)
            chk("baud_clk_timeout", n, -1);
    endtask

    task automatic wait_baud(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!baud_tick && n < 2000);
        if (!baud_tick)
            chk("baud_tick_timeout", n, -1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        sync_clr = 1'b0;
        div_load = 1'b0;
        #12;
        reset = 1'b0;
        step();
    endtask

    task automatic load_div(input logic [DW-1:0] d);
        div_in   = d;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    initial begin
        int n, m, s, lo, hi, bidx, bcnt;
        vec_t e;

        vecs[0] = '{24'h000400, 8, 32, 4, 4, 1'b0};
        vecs[1] = '{24'h000280, 4, 10, 2, 3, 1'b0};
        vecs[2] = '{24'h000100, 4, 8, 2, 2, 1'b1};
        vecs[3] = '{24'h000600, 4, 24, 6, 6, 1'b0};
        vecs[4] = '{24'h000000, 4, 8, 2, 2, 1'b1};

        // Reset defaults
        do_reset();
        chk("rst_os_tick", os_tick, 0);
        chk("rst_baud_tick", baud_tick, 0);
        chk("rst_baud_clk", baud_clk_out, 1);
        chk("rst_pending", div_pending, 0);
        chk("rst_err", div_err, 0);

        // Default 27.125 divisor
        enable = 1'b1;
        exp_q.push_back(217);
        exp_q.push_back(217);
        lo = 1000; hi = 0; bidx = 0; bcnt = 0;
        for (int g = 0; g < 2; g++) begin
            s = 0;
            for (int k = 0; k < 8; k++) begin
                wait_tick(n);
                s += n;
                if (n < lo) lo = n;
                if (n > hi) hi = n;
                if (baud_tick) begin
                    bcnt++;
                    bidx = g * 8 + k + 1;
                end
            end
            chk("def_sum8", s, exp_q.pop_front());
        end
        chk("def_min_iv", lo, 27);
        chk("def_max_iv", hi, 28);
        chk("def_baud_idx", bidx, 16);
        chk("def_baud_cnt", bcnt, 1);

        // Table of loaded divisors
        foreach (vecs[i]) begin
            do_reset();
            load_div(vecs[i].div);
            chk("tbl_pending_set", div_pending, 1);
            step();
            chk("tbl_pending_clr", div_pending, 0);
            sb.push_back(vecs[i]);
            enable = 1'b1;
            s = 0; lo = 1000; hi = 0;
            for (int k = 0; k < vecs[i].nt; k++) begin
                wait_tick(n);
                s += n;
                if (n < lo) lo = n;
                if (n > hi) hi = n;
            end
            e = sb.pop_front();
            chk("tbl_sum", s, e.sum);
            chk("tbl_min_iv", lo, e.lo);
            chk("tbl_max_iv", hi, e.hi);
            chk("tbl_err", div_err, e.err);
        end

        // Divisor 4.0: baud clock shape and baud_tick period
        do_reset();
        load_div(24'h000400);
        step();
        enable = 1'b1;
        wait_bclk(1'b0, n);
        chk("d4_first_high", n, 32);
        wait_bclk(1'b1, n);
        chk("d4_low", n, 32);
        chk("d4_baud_at_rise", baud_tick, 1);
        wait_baud(n);
        chk("d4_baud_period", n, 64);

        // Mid-run load 4.0 -> 6.0
        wait_tick(n);
        step();
        load_div(24'h000600);
        chk("mid_pending_set", div_pending, 1);
        step();
        chk("mid_pending_hold", div_pending, 1);
        exp_q.push_back(4);
        wait_tick(m);
        chk("mid_cur_iv", 3 + m, exp_q.pop_front());
        chk("mid_pending_clr", div_pending, 0);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(6);
            wait_tick(n);
            chk("mid_new_iv", n, exp_q.pop_front());
        end

        // Freeze mid-interval
        step();
        step();
        enable = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (os_tick || baud_tick) bcnt++;
        end
        chk("frz_no_ticks", bcnt, 0);
        enable = 1'b1;
        wait_tick(n);
        chk("frz_remaining", n, 4);

        // sync_clr realign
        wait_bclk(1'b0, n);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("sync_os_tick", os_tick, 0);
        chk("sync_baud_clk", baud_clk_out, 1);
        wait_tick(n);
        chk("sync_first_iv", n, 6);

        // Async reset between edges
        load_div(24'h000100);
        chk("clamp_err", div_err, 1);
        wait_bclk(1'b0, n);
        wait_tick(n);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_os_tick", os_tick, 0);
        chk("arst_baud_clk", baud_clk_out, 1);
        chk("arst_err", div_err, 0);
        chk("arst_pending", div_pending, 0);
        #3;
        reset = 1'b0;
        wait_tick(n);
        chk("arst_def_first", n, 28);
        wait_tick(n);
        chk("arst_def_second", n, 27);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
